// File: rtl/tender_pkg.sv
// Shared definitions for the RT_TENDER decomposition core.
//   - Default geometry: element width, channels per row, rows per tile,
//     number of groups and the group-index width.
//   - state_t   : scan/emit state of the channel-max scanner.
//   - grp_idx_t : group index type carried with every channel record.
package tender_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_CH   = 16;
    localparam int NUM_ROWS = 8;
    localparam int NUM_GRP  = 8;
    localparam int GRP_W    = 3;

    typedef enum logic {
        SCAN = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef logic [GRP_W-1:0] grp_idx_t;

endpackage

// File: rtl/tender_grp_classify.sv
// Power-of-two group classifier.
// The group is the smallest g in 0..NUM_GRP-2 for which m exceeds the
// global max shifted right by g+1; otherwise (including m == 0) the last
// group NUM_GRP-1.
// Ports:
//   m     in  DATA_W  unsigned channel absolute max
//   g_max in  DATA_W  unsigned tile-global absolute max
//   grp   out GRP_W   group index
module tender_grp_classify
    import tender_pkg::*;
#(
    parameter int P_DATA_W  = DATA_W,
    parameter int P_NUM_GRP = NUM_GRP,
    parameter int P_GRP_W   = GRP_W
) (
    input  logic [P_DATA_W-1:0] m,
    input  logic [P_DATA_W-1:0] g_max,
    output logic [P_GRP_W-1:0]  grp
);

    // Walk from the coarsest threshold down so the last hit is the smallest g.
    // m == 0 can never exceed a shifted value, so it falls through to the
    // default last group.
    always_comb begin
        grp = P_GRP_W'(P_NUM_GRP - 1);
        for (int g = P_NUM_GRP - 2; g >= 0; g--) begin
            if (m > (g_max >> (g + 1))) begin
                grp = P_GRP_W'(g);
            end
        end
    end

endmodule

// File: rtl/tender_chan_max_scan.sv
// Upstream stage of the RT_TENDER decomposition core.
// Consumes one activation tile (row-major, channel fastest) as a signed
// element stream, tracks per-channel and tile-global absolute maxima, then
// emits one record per channel: {channel, max, group index}.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   in_valid/ready   element handshake (ready only while scanning)
//   in_data          signed activation element
//   out_valid/ready  channel record handshake
//   out_ch           channel index of the record
//   out_max          unsigned absolute max of that channel
//   out_grp          power-of-two group of that channel
//   out_last         record belongs to the final channel
//   busy             high unless idle in SCAN at the tile start
module tender_chan_max_scan
    import tender_pkg::*;
#(
    parameter int P_DATA_W   = DATA_W,
    parameter int P_NUM_CH   = NUM_CH,
    parameter int P_NUM_ROWS = NUM_ROWS,
    parameter int P_NUM_GRP  = NUM_GRP,
    parameter int P_GRP_W    = GRP_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [P_DATA_W-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(P_NUM_CH)-1:0]   out_ch,
    output logic [P_DATA_W-1:0]           out_max,
    output logic [P_GRP_W-1:0]            out_grp,
    output logic                          out_last,
    output logic                          busy
);

    localparam int CH_W  = $clog2(P_NUM_CH);
    localparam int ROW_W = $clog2(P_NUM_ROWS);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(P_NUM_CH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_NUM_ROWS - 1);

    state_t               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [CH_W-1:0]      e_q, e_d;
    logic [P_DATA_W-1:0]  gmax_q, gmax_d;
    logic [P_DATA_W-1:0]  chmax_q [P_NUM_CH];
    logic [P_DATA_W-1:0]  chmax_d [P_NUM_CH];

    logic                 accept;
    logic                 tile_done;
    logic                 emit_hs;
    logic                 emit_done;
    logic [P_DATA_W-1:0]  abs_val;
    logic [P_NUM_CH-1:0]  ch_sel;

    assign in_ready  = (state_q == SCAN);
    assign accept    = in_valid && in_ready;
    assign tile_done = accept && (ch_q == CH_LAST) && (row_q == ROW_LAST);
    assign emit_hs   = (state_q == EMIT) && out_ready;
    assign emit_done = emit_hs && (e_q == CH_LAST);

    // Two's-complement magnitude; the most negative value wraps to
    // 2^(DATA_W-1), which is exactly its magnitude as an unsigned number.
    assign abs_val = in_data[P_DATA_W-1] ? P_DATA_W'(~in_data + 1'b1)
                                         : P_DATA_W'(in_data);

    // One-hot channel write enable for the current accepted element.
    generate
        for (genvar gi = 0; gi < P_NUM_CH; gi++) begin : g_ch_sel
            assign ch_sel[gi] = accept && (ch_q == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        row_d   = row_q;
        e_d     = e_q;
        gmax_d  = gmax_q;
        for (int c = 0; c < P_NUM_CH; c++) begin
            chmax_d[c] = chmax_q[c];
        end

        if (accept) begin
            if (ch_q == CH_LAST) begin
                ch_d  = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                ch_d = ch_q + 1'b1;
            end
            if (abs_val > gmax_q) begin
                gmax_d = abs_val;
            end
            for (int c = 0; c < P_NUM_CH; c++) begin
                if (ch_sel[c] && (abs_val > chmax_q[c])) begin
                    chmax_d[c] = abs_val;
                end
            end
        end

        if (tile_done) begin
            state_d = EMIT;
        end

        if (emit_hs) begin
            e_d = (e_q == CH_LAST) ? '0 : e_q + 1'b1;
        end

        // Final record handed off: clear the statistics for the next tile.
        if (emit_done) begin
            state_d = SCAN;
            gmax_d  = '0;
            for (int c = 0; c < P_NUM_CH; c++) begin
                chmax_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SCAN;
            ch_q    <= '0;
            row_q   <= '0;
            e_q     <= '0;
            gmax_q  <= '0;
            for (int c = 0; c < P_NUM_CH; c++) begin
                chmax_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            e_q     <= e_d;
            gmax_q  <= gmax_d;
            for (int c = 0; c < P_NUM_CH; c++) begin
                chmax_q[c] <= chmax_d[c];
            end
        end
    end

    tender_grp_classify #(
        .P_DATA_W  (P_DATA_W),
        .P_NUM_GRP (P_NUM_GRP),
        .P_GRP_W   (P_GRP_W)
    ) u_classify (
        .m     (chmax_q[e_q]),
        .g_max (gmax_q),
        .grp   (out_grp)
    );

    // Every record output is a pure function of flops, so it holds
    // naturally while the downstream stalls.
    assign out_valid = (state_q == EMIT);
    assign out_ch    = e_q;
    assign out_max   = chmax_q[e_q];
    assign out_last  = (state_q == EMIT) && (e_q == CH_LAST);
    assign busy      = !((state_q == SCAN) && (ch_q == '0) && (row_q == '0));

endmodule

// File: tb/tb_tender_chan_max_scan.sv
module tb_tender_chan_max_scan;

    localparam int NCH   = 16;
    localparam int NROW  = 8;
    localparam int NELEM = NCH * NROW;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_ch;
    logic [7:0]        out_max;
    logic [2:0]        out_grp;
    logic              out_last;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int accepted;

    logic signed [7:0] tile_mem [NELEM];
    logic [7:0]        exp_max  [NCH];
    logic [2:0]        exp_grp  [NCH];
    logic [7:0]        obs_max  [NCH];
    logic [2:0]        obs_grp  [NCH];

    tender_chan_max_scan dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_max   (out_max),
        .out_grp   (out_grp),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Group reference: smallest g with m > (G >> (g+1)), else last group.
    function automatic logic [2:0] ref_grp(input logic [7:0] m, input logic [7:0] g_max);
        if (m == 8'd0) return 3'd7;
        for (int g = 0; g < 7; g++) begin
            if (m > (g_max >> (g + 1))) return 3'(g);
        end
        return 3'd7;
    endfunction

    task automatic ref_compute();
        logic [7:0] gm;
        logic [7:0] a;
        gm = 8'd0;
        for (int c = 0; c < NCH; c++) exp_max[c] = 8'd0;
        for (int i = 0; i < NELEM; i++) begin
            a = (tile_mem[i] < 0) ? 8'(-int'(tile_mem[i])) : 8'(tile_mem[i]);
            if (a > exp_max[i % NCH]) exp_max[i % NCH] = a;
            if (a > gm) gm = a;
        end
        for (int c = 0; c < NCH; c++) exp_grp[c] = ref_grp(exp_max[c], gm);
    endtask

    // Offer tile_mem elements until n are accepted; gaps randomly idle in_valid.
    task automatic drive_tile(input bit gaps, input int n);
        int cyc;
        bit acc;
        accepted = 0;
        cyc = 0;
        while (accepted < n && cyc < 4000) begin
            @(negedge clk);
            if (gaps && ($urandom_range(1, 0) == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = tile_mem[accepted];
            end
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) accepted++;
            cyc++;
        end
        check("accept_count", 32'(accepted), 32'(n));
    endtask

    // Starts on the negedge right after the final accept. in_valid is kept
    // high with a large value during EMIT to show it is ignored.
    task automatic collect(input int hold, input string name);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'sd127;
        out_ready = (hold == 0);
        for (int k = 0; k < hold; k++) begin
            #1;
            check($sformatf("%s_hold%0d_valid", name, k), 32'(out_valid), 32'd1);
            check($sformatf("%s_hold%0d_ch", name, k), 32'(out_ch), 32'd0);
            check($sformatf("%s_hold%0d_max", name, k), 32'(out_max), 32'(exp_max[0]));
            check($sformatf("%s_hold%0d_grp", name, k), 32'(out_grp), 32'(exp_grp[0]));
            check($sformatf("%s_hold%0d_in_ready", name, k), 32'(in_ready), 32'd0);
            @(negedge clk);
            if (k == hold - 1) out_ready = 1'b1;
        end
        for (int r = 0; r < NCH; r++) begin
            #1;
            obs_max[r] = out_max;
            obs_grp[r] = out_grp;
            check($sformatf("%s_r%0d_valid", name, r), 32'(out_valid), 32'd1);
            check($sformatf("%s_r%0d_ch", name, r), 32'(out_ch), 32'(r));
            check($sformatf("%s_r%0d_max", name, r), 32'(out_max), 32'(exp_max[r]));
            check($sformatf("%s_r%0d_grp", name, r), 32'(out_grp), 32'(exp_grp[r]));
            check($sformatf("%s_r%0d_last", name, r), 32'(out_last), 32'(r == NCH - 1));
            check($sformatf("%s_r%0d_in_ready", name, r), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check($sformatf("%s_after_in_ready", name), 32'(in_ready), 32'd1);
        check($sformatf("%s_after_valid", name), 32'(out_valid), 32'd0);
        check($sformatf("%s_after_busy", name), 32'(busy), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'sd0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Tile 1: every element of channel c equals c (gmax 15).
        for (int i = 0; i < NELEM; i++) tile_mem[i] = 8'(i % NCH);
        for (int c = 0; c < NCH; c++) begin
            exp_max[c] = 8'(c);
            exp_grp[c] = (c >= 8) ? 3'd0 : (c >= 4) ? 3'd1 : (c >= 2) ? 3'd2 :
                         (c == 1) ? 3'd3 : 3'd7;
        end
        drive_tile(1'b0, NELEM);
        collect(0, "ramp");

        // Tile 2: values in [-5,5], one -128 in channel 3.
        for (int i = 0; i < NELEM; i++) tile_mem[i] = 8'((((i / NCH) + (i % NCH)) % 11) - 5);
        tile_mem[2 * NCH + 3] = -8'sd128;
        ref_compute();
        drive_tile(1'b0, NELEM);
        collect(0, "neg128");
        check("neg128_ch3_max", 32'(obs_max[3]), 32'd128);
        check("neg128_ch3_grp", 32'(obs_grp[3]), 32'd0);
        check("neg128_ch5_max", 32'(obs_max[5]), 32'd5);
        check("neg128_ch5_grp", 32'(obs_grp[5]), 32'd4);

        // Tile 3: gmax 127, ch0 max 1, ch1 max 2; out_ready held low 5 cycles.
        for (int i = 0; i < NELEM; i++) begin
            case (i % NCH)
                0:       tile_mem[i] = ((i / NCH) % 2 == 0) ? 8'sd1 : -8'sd1;
                1:       tile_mem[i] = ((i / NCH) == 0) ? 8'sd2 : 8'sd0;
                2:       tile_mem[i] = ((i / NCH) == 3) ? 8'sd127 : 8'sd0;
                default: tile_mem[i] = 8'((((i / NCH) * (i % NCH)) % 7) - 3);
            endcase
        end
        ref_compute();
        drive_tile(1'b0, NELEM);
        collect(5, "hold");
        check("hold_ch0_grp", 32'(obs_grp[0]), 32'd6);
        check("hold_ch1_grp", 32'(obs_grp[1]), 32'd5);
        check("hold_ch2_grp", 32'(obs_grp[2]), 32'd0);

        // Partial tile then asynchronous reset: no record, counters cleared.
        for (int i = 0; i < NELEM; i++) tile_mem[i] = 8'(i * 7 + 33);
        drive_tile(1'b0, 70);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("partial_busy", 32'(busy), 32'd1);
        check("partial_valid", 32'(out_valid), 32'd0);
        rstn = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < NELEM; i++) tile_mem[i] = 8'sd0;
        for (int c = 0; c < NCH; c++) begin
            exp_max[c] = 8'd0;
            exp_grp[c] = 3'd7;
        end
        drive_tile(1'b0, NELEM);
        collect(0, "zero");

        // Random tile with ~50% in_valid gaps against the reference model.
        for (int i = 0; i < NELEM; i++) tile_mem[i] = 8'($urandom_range(255, 0));
        tile_mem[$urandom_range(NELEM - 1, 0)] = -8'sd128;
        ref_compute();
        drive_tile(1'b1, NELEM);
        collect(0, "rand");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tender_chan_max_scan.md
Name: tender_chan_max_scan

Overview:
- Upstream stage of the RT_TENDER decomposition core.
- Consumes one activation tile as a signed element stream in row-major order, with channel index fastest.
- Tracks the per-channel absolute maximum and the tile-global maximum.
- After the tile, emits one record per channel: max_val plus a power-of-two group index grp_idx. RT_TENDER consumes these records to build its tensor decomposition.

Parameters:
- DATA_W, 8: signed element width.
- NUM_CH, 16: channels per row.
- NUM_ROWS, 8: rows per tile.
- NUM_GRP, 8: number of groups.
- GRP_W, 3: grp_idx width, equal to clog2(NUM_GRP).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts an element
- in_data  in  DATA_W  signed activation element
- out_valid  out  1  channel record valid
- out_ready  in  1  downstream accepts the record
- out_ch  out  clog2(NUM_CH)  channel index of the record
- out_max  out  DATA_W  unsigned absolute max of the channel
- out_grp  out  GRP_W  group index of the channel
- out_last  out  1  record is for channel NUM_CH-1
- busy  out  1  high whenever not in SCAN with element count 0

Behaviour:
- Interface: single clock clk; reset rstn is asynchronous and active-low.
- Reset values:
  - state = SCAN.
  - Channel counter, row counter, gmax and all chmax entries = 0.
  - in_ready = 1 (combinational from state), out_valid = 0, busy = 0.
- State SCAN:
  - in_ready = 1.
  - An element is accepted when in_valid and in_ready are both high.
  - abs = |in_data|, zero-extended to DATA_W unsigned. -2^(DATA_W-1) maps to 2^(DATA_W-1) (-128 gives 128); no saturation.
  - chmax[ch] = max(chmax[ch], abs) and gmax = max(gmax, abs), both updated in the accept cycle.
  - ch increments and wraps at NUM_CH-1; on wrap, row increments.
  - On the accept of ch = NUM_CH-1 and row = NUM_ROWS-1: counters clear and state becomes EMIT on the next edge.
- State EMIT:
  - in_ready = 0.
  - out_valid = 1; out_ch = the emit index e, starting at 0.
  - out_max = chmax[e]; out_grp = classify(chmax[e], gmax); out_last = (e == NUM_CH-1).
  - While out_ready = 0, all outputs hold stable.
  - On a handshake, e increments.
  - On the handshake with out_last = 1: all chmax entries, gmax and e clear, and state returns to SCAN on the next edge. in_ready is high in the following cycle.
- Latency:
  - The first record is valid in the cycle after the last element is accepted.
  - With out_ready held high, records stream at one per cycle.
- classify(m, G):
  - If m == 0, the group is NUM_GRP-1.
  - Otherwise, the group is the smallest g in 0..NUM_GRP-2 with m > (G >> (g+1)).
  - If no such g exists, the group is NUM_GRP-1.
  - The shift is logical on DATA_W-bit unsigned values.
- Boundary conditions:
  - An all-zero tile gives every channel group NUM_GRP-1.
  - A channel with m == G is always group 0 (when G > 0).
  - in_valid during EMIT is ignored; no element is accepted.
- Reset mid-operation: the partial tile is discarded, no record is emitted, and the next accepted element is (row 0, ch 0).

Decomposition:
- Shared package tender_pkg holds:
  - The DATA_W, NUM_CH, NUM_ROWS, NUM_GRP and GRP_W defaults.
  - The state enumeration {SCAN, EMIT}.
  - The grp_idx type.
- One combinational sub-module, tender_grp_classify, with inputs m and G and output grp. It is reused later by RT_TENDER's requantizer.

Test Plan:
- Default params, every element of channel c equals c → gmax 15. Channel records in order:
  - ch8..15: grp 0
  - ch4..7: grp 1
  - ch2..3: grp 2
  - ch1: grp 3
  - ch0: out_max 0, grp 7
  - ch15 has out_last = 1.
- One element of -128 in ch3, all others in [-5, 5] → ch3 out_max 128, grp 0. A channel with max 5 gets grp 4, since 5 > 128>>5 = 4.
- Tile with gmax 127 and ch0 max 1 → ch0 grp 6 (1 > 127>>7 = 0). A channel with max 2 gets grp 5.
- out_ready held low for 5 cycles during EMIT → out_* stable and in_ready = 0. Releasing out_ready streams 16 records on consecutive cycles, and in_ready rises in the cycle after the out_last handshake.
- rstn pulsed low after 70 accepted elements → out_valid and busy are 0 immediately. A fresh all-zero tile then yields 16 records, all with out_max 0 and grp 7.
- Random in_valid gaps (50%) on a random tile → records match a reference model. Exactly NUM_ROWS*NUM_CH elements are accepted per tile.
